// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
// Turns the raw keypad key stream into debounced, single-shot digit events.
// Up to MAX_DIGITS decimal digits are assembled into an 8-bit operand
// (0..255). A committed operand is offered to the datapath over a
// valid/ready handshake.
//
// Ports:
//   clk            system clock
//   rst_n          synchronous active-low reset
//   key_value      decoded digit, meaningful only while key_valid=1
//   key_valid      a digit key is currently held
//   enter          single-cycle pulse: commit the accumulated operand
//   clear          single-cycle pulse: discard the accumulated entry
//   operand        committed operand, stable while operand_valid=1
//   operand_valid  operand available to the datapath
//   operand_ready  datapath accepts the operand
//   acc            in-progress accumulator (display)
//   digit_count    number of digits in acc
//   overflow       sticky: a digit was rejected since the last clear/commit
//   busy           key FSM is not idle
module keypad_entry_ctrl #(
    parameter int DEBOUNCE   = 16,
    parameter int MAX_DIGITS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_value,
    input  logic       key_valid,
    input  logic       enter,
    input  logic       clear,
    output logic [7:0] operand,
    output logic       operand_valid,
    input  logic       operand_ready,
    output logic [7:0] acc,
    output logic [1:0] digit_count,
    output logic       overflow,
    output logic       busy
);

    localparam int         CW       = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
    localparam logic [1:0] MAX_CNT  = 2'(MAX_DIGITS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } keyState_e;

    keyState_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    key_q, key_d;
    logic          digitAccept;

    logic [7:0]    acc_q, acc_d;
    logic [1:0]    count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    operand_q, operand_d;
    logic          valid_q, valid_d;

    logic          enterOk;
    logic [7:0]    baseAcc;
    logic [1:0]    baseCount;
    logic [11:0]   newVal;

    // Key FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            key_q     <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            operand_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            operand_q <= operand_d;
            valid_q   <= valid_d;
        end
    end

    // Key FSM: a press must stay stable on the same digit for DEBOUNCE
    // cycles before one digit_accept fires; a release must stay stable
    // for DEBOUNCE cycles before a new press can start.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        digitAccept = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    state_d = PRESS_DB;
                    key_d   = key_value;
                    cnt_d   = '0;
                end
            end
            PRESS_DB: begin
                if (!key_valid || (key_value != key_q)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = HELD;
                    digitAccept = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!key_valid) begin
                    state_d = REL_DB;
                    cnt_d   = '0;
                end
            end
            REL_DB: begin
                if (key_valid) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Accumulator and handshake. Priority is clear > enter > digit.
    // An accepted enter empties the entry first, so a digit arriving in
    // the same cycle starts the next operand from zero.
    always_comb begin
        acc_d     = acc_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        operand_d = operand_q;
        valid_d   = valid_q;
        baseAcc   = acc_q;
        baseCount = count_q;
        newVal    = '0;
        enterOk   = enter && (count_q != 2'd0) && !valid_q;

        if (valid_q && operand_ready) begin
            valid_d = 1'b0;
        end

        if (clear) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (enterOk) begin
                operand_d = acc_q;
                valid_d   = 1'b1;
                baseAcc   = '0;
                baseCount = '0;
                acc_d     = '0;
                count_d   = '0;
                ovf_d     = 1'b0;
            end
            if (digitAccept) begin
                newVal = 12'(baseAcc) * 12'd10 + 12'(key_q);
                if (key_q > 4'd9) begin
                    ovf_d = 1'b1;
                end else if (baseCount == MAX_CNT) begin
                    ovf_d = 1'b1;
                end else if (newVal > 12'd255) begin
                    ovf_d = 1'b1;
                end else begin
                    acc_d   = newVal[7:0];
                    count_d = baseCount + 2'd1;
                end
            end
        end
    end

    assign operand       = operand_q;
    assign operand_valid = valid_q;
    assign acc           = acc_q;
    assign digit_count   = count_q;
    assign overflow      = ovf_q;
    assign busy          = (state_q != IDLE);

endmodule
